// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array front end: lane geometry,
// write-enable polarity and the skew feeder state encoding.
package systolic_pkg;

  localparam int N_LANES = 4;
  localparam int LANE_DW = 8;

  // Array PEs accumulate while WEN is low.
  localparam logic WEN_ACTIVE = 1'b0;
  localparam logic WEN_IDLE   = 1'b1;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/systolic_skew_feeder_skew_line.sv
// One lane delay line: DEPTH register stages carrying {wen, data}. Idle stages
// hold wen=idle and data=0 so the array edge never sees stale operands.
module skew_line
  import systolic_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          wen_i,
  input  logic [DW-1:0] data_i,
  output logic          wen_o,
  output logic [DW-1:0] data_o
);

  logic [DEPTH-1:0] wen_q;
  logic [DW-1:0]    data_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q <= {DEPTH{WEN_IDLE}};
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else if (clr_i) begin
      wen_q <= {DEPTH{WEN_IDLE}};
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      wen_q[0]  <= wen_i;
      data_q[0] <= data_i;
      for (int k = 1; k < DEPTH; k++) begin
        wen_q[k]  <= wen_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

  assign wen_o  = wen_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers one tile of row vectors, then streams it gap-free into the array edge
// with lane i delayed i cycles, followed by an N-cycle flush and a done pulse.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N        = N_LANES,
  parameter int DW       = LANE_DW,
  parameter int TILE_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          soft_clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic          in_last,
  output logic [N*DW-1:0] feed_data,
  output logic [N-1:0]  feed_wen,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state_dbg
);

  localparam int CW = $clog2(TILE_LEN + 1);
  localparam int FW = $clog2(N + 1);
  localparam int AW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;

  feeder_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [N*DW-1:0] buf_q [TILE_LEN];

  logic          accept;
  logic          tile_end;
  logic [N-1:0]  line_wen;
  logic [N*DW-1:0] line_data;

  // Handshake: a vector transfers on a clock edge where in_valid and in_ready
  // are both high; in_ready depends only on state, never on in_valid.
  assign accept   = in_valid && (state_q == ST_FILL);
  assign tile_end = accept && (in_last || (count_q == CW'(TILE_LEN - 1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL:   if (tile_end) state_d = ST_STREAM;
      ST_STREAM: if (rd_q == len_q - CW'(1)) state_d = ST_FLUSH;
      ST_FLUSH:  if (flush_q == FW'(N - 1)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_FILL;
      default:   state_d = ST_FILL;
    endcase
    if (soft_clr) state_d = ST_FILL;
  end

  always_comb begin
    in_ready  = (state_q == ST_FILL);
    busy      = (state_q != ST_FILL);
    done      = (state_q == ST_DONE);
    state_dbg = state_q;
    line_wen  = {N{WEN_IDLE}};
    line_data = '0;
    if (state_q == ST_STREAM) begin
      line_wen  = {N{WEN_ACTIVE}};
      line_data = buf_q[rd_q[AW-1:0]];
    end
  end

  always_comb begin
    count_d = count_q;
    len_d   = len_q;
    rd_d    = rd_q;
    flush_d = flush_q;
    if (soft_clr) begin
      count_d = '0;
      rd_d    = '0;
      flush_d = '0;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (accept) count_d = count_q + CW'(1);
          if (tile_end) begin
            len_d = count_q + CW'(1);
            rd_d  = '0;
          end
        end
        ST_STREAM: begin
          rd_d    = rd_q + CW'(1);
          flush_d = '0;
        end
        ST_FLUSH: flush_d = flush_q + FW'(1);
        ST_DONE: begin
          count_d = '0;
          rd_d    = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      len_q   <= '0;
      rd_q    <= '0;
      flush_q <= '0;
    end else begin
      count_q <= count_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      flush_q <= flush_d;
    end
  end

  // Tile storage needs no reset: it is only read after being written.
  always_ff @(posedge clk) begin
    if (accept && !soft_clr) buf_q[count_q[AW-1:0]] <= in_data;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(
      .DEPTH (i + 1),
      .DW    (DW)
    ) u_line (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (soft_clr),
      .wen_i  (line_wen[i]),
      .data_i (line_data[i*DW +: DW]),
      .wen_o  (feed_wen[i]),
      .data_o (feed_data[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed tiles, expected edge words queued
// with their cycle numbers, checked by an independent output monitor.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TL = 4;
  localparam int WW = 1 + N + N * DW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            soft_clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic            in_ready;
  logic [N*DW-1:0] feed_data;
  logic [N-1:0]    feed_wen;
  logic            busy;
  logic            done;
  logic [1:0]      state_dbg;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [WW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  systolic_skew_feeder #(.N(N), .DW(DW), .TILE_LEN(TL)) dut (
    .clk       (clk),
    .rst       (rst),
    .soft_clr  (soft_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .feed_data (feed_data),
    .feed_wen  (feed_wen),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected {done, feed_wen, feed_data} in cycle S+c of a tile of length len.
  function automatic logic [WW-1:0] exp_word(input logic [N*DW-1:0] v[TL], input int len, input int c);
    logic [N-1:0]    w;
    logic [N*DW-1:0] d;
    w = '1;
    d = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = c - 1 - i;
      if (j >= 0 && j < len) begin
        w[i] = 1'b0;
        d[i*DW +: DW] = v[j][i*DW +: DW];
      end
    end
    return {(c == len + N), w, d};
  endfunction

  // Driver: offers vectors under in_valid pattern vpat; on the final accept
  // queues the first nwords expected edge words. Returns at cycle S.
  task automatic send_tile(input logic [N*DW-1:0] v[TL], input int len, input logic [15:0] vpat,
                           input int nwords, output int s);
    int idx;
    idx = 0;
    s = 0;
    for (int k = 0; k < 16 && idx < len; k++) begin
      @(posedge clk); #1;
      in_valid = vpat[k];
      in_data  = v[idx];
      in_last  = (idx == len - 1) && (len < TL);
      if (vpat[k]) begin
        check("fill_ready", in_ready, 1);
        if (idx == len - 1) begin
          s = cyc + 1;
          for (int c = 1; c <= nwords; c++) begin
            exp_q.push_back(exp_word(v, len, c));
            exp_cyc_q.push_back(s + c);
          end
        end
        idx++;
      end
    end
    if (idx < len) check("fill_timeout", idx, len);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    check("stream_ready_low", in_ready, 0);
    check("stream_busy", busy, 1);
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor / scoreboard: any cycle with an active lane or done must match the
  // next queued word, in the queued cycle.
  always @(negedge clk) begin : monitor
    logic [WW-1:0] w;
    int c;
    if (rst && (feed_wen !== '1 || done !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {done, feed_wen, feed_data}, {1'b0, {N{1'b1}}, {N*DW{1'b0}}});
      end else begin
        w = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("feed_word", {done, feed_wen, feed_data}, w);
        check("feed_cycle", cyc, c);
      end
    end
  end

  initial begin : stim
    logic [N*DW-1:0] t2[TL];
    logic [N*DW-1:0] t4[TL];
    int s;
    t2 = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    t4 = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 32'hD3D2D1D0};

    // Reset and release
    wait_cycles(2);
    check("rst_wen", feed_wen, 4'hF);
    check("rst_data", feed_data, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    wait_cycles(1);
    check("rel_ready", in_ready, 1);
    check("rel_state", state_dbg, 0);

    // Full tile back-to-back
    send_tile(t2, 4, 16'hFFFF, 8, s);
    wait_cycles(8);
    check("full_done", done, 1);
    check("full_done_busy", busy, 1);
    wait_cycles(1);
    check("full_ready_back", in_ready, 1);
    check("full_done_pulse", done, 0);
    check("full_idle_busy", busy, 0);

    // Short tile, in_last on the second vector
    send_tile(t2, 2, 16'hFFFF, 6, s);
    wait_cycles(6);
    check("short_done", done, 1);
    wait_cycles(1);
    check("short_ready_back", in_ready, 1);

    // Gappy fill: valid pattern 1,0,0,1,1,0,1
    send_tile(t4, 4, 16'h0059, 8, s);
    wait_cycles(9);

    // soft_clr together with an accept drops the vector
    wait_cycles(1);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    soft_clr = 1'b1;
    wait_cycles(1);
    in_valid = 1'b0;
    soft_clr = 1'b0;
    check("clr_accept_ready", in_ready, 1);

    // soft_clr at S+2 of a full tile
    send_tile(t4, 4, 16'hFFFF, 2, s);
    wait_cycles(2);
    soft_clr = 1'b1;
    wait_cycles(1);
    soft_clr = 1'b0;
    check("clr_wen", feed_wen, 4'hF);
    check("clr_data", feed_data, 0);
    check("clr_ready", in_ready, 1);
    check("clr_busy", busy, 0);
    wait_cycles(8);
    send_tile(t2, 4, 16'hFFFF, 8, s);
    wait_cycles(9);

    // Asynchronous reset during FLUSH
    send_tile(t4, 4, 16'hFFFF, 4, s);
    wait_cycles(5);
    #1;
    rst = 1'b0;
    #1;
    check("arst_wen", feed_wen, 4'hF);
    check("arst_data", feed_data, 0);
    check("arst_done", done, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 1);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(1);
    send_tile(t2, 2, 16'hFFFF, 6, s);
    wait_cycles(7);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
